// File: rtl/ram_asym_port.sv
// Asymmetric-width simple dual-port RAM: lane-sliced storage, per-lane masked
// writes, per-lane read-during-write resolution and a 1- or 2-stage read pipeline.
module ram_asym_port #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RATIO         = 4,
  parameter int unsigned WIDE_ADDR_W   = 6,
  parameter int unsigned MODE          = 0,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned COLLISION_FWD = 1,
  localparam int unsigned LW            = $clog2(RATIO),
  localparam int unsigned NARROW_ADDR_W = WIDE_ADDR_W + LW,
  localparam int unsigned WIDE_DW       = RATIO * DATA_WIDTH,
  localparam int unsigned WR_DW         = (MODE != 0) ? DATA_WIDTH : WIDE_DW,
  localparam int unsigned WR_AW         = (MODE != 0) ? NARROW_ADDR_W : WIDE_ADDR_W,
  localparam int unsigned RD_DW         = (MODE != 0) ? WIDE_DW : DATA_WIDTH,
  localparam int unsigned RD_AW         = (MODE != 0) ? WIDE_ADDR_W : NARROW_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_write_req,
  input  logic [WR_AW-1:0] s_write_addr,
  input  logic [WR_DW-1:0] s_write_data,
  input  logic [RATIO-1:0] s_write_mask,
  input  logic             s_read_req,
  input  logic [RD_AW-1:0] s_read_addr,
  output logic [RD_DW-1:0] s_read_data,
  output logic             s_read_valid
);

  localparam int unsigned DEPTH = 2 ** WIDE_ADDR_W;

  logic                   wr_go;
  logic                   rd_go;
  logic [WIDE_ADDR_W-1:0] wr_row;
  logic [WIDE_ADDR_W-1:0] rd_row;
  logic [LW-1:0]          rd_lane;
  logic [RATIO-1:0]       wr_en;
  logic [WIDE_DW-1:0]     wr_wide;
  logic [WIDE_DW-1:0]     rd_wide;
  logic                   ld;
  logic [RD_DW-1:0]       ld_data;

  // Reset blocks writes and refuses read requests.
  assign wr_go = s_write_req & ~reset;
  assign rd_go = s_read_req & ~reset;

  // Lane selection from the narrow final-stage read (MODE 0) or the whole row (MODE 1).
  function automatic logic [RD_DW-1:0] pick(input logic [WIDE_DW-1:0] row,
                                            input logic [LW-1:0]      lane);
    if (MODE == 0) return RD_DW'(row >> (32'(lane) * DATA_WIDTH));
    else           return RD_DW'(row);
  endfunction

  // Address/data decode for the chosen width direction.
  if (MODE == 0) begin : g_wide_wr
    assign wr_row  = s_write_addr;
    assign wr_wide = s_write_data;
    assign wr_en   = {RATIO{wr_go}} & s_write_mask;
    assign rd_row  = s_read_addr[NARROW_ADDR_W-1:LW];
    assign rd_lane = s_read_addr[LW-1:0];
  end else begin : g_narrow_wr
    logic unused_mask;
    assign unused_mask = ^s_write_mask;
    assign wr_row  = s_write_addr[NARROW_ADDR_W-1:LW];
    assign wr_wide = {RATIO{s_write_data}};
    assign wr_en   = wr_go ? (RATIO'(1) << s_write_addr[LW-1:0]) : '0;
    assign rd_row  = s_read_addr;
    assign rd_lane = '0;
  end

  // One storage bank per lane; collisions are resolved lane by lane.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_d;
    logic                  hit;

    assign wr_d = wr_wide[i*DATA_WIDTH +: DATA_WIDTH];
    assign hit  = (COLLISION_FWD != 0) && wr_en[i] && (wr_row == rd_row);

    // Lane write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
      if (wr_en[i]) mem[wr_row] <= wr_d;
    end

    assign rd_wide[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wr_d : mem[rd_row];
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic               s1_valid;
    logic [WIDE_DW-1:0] s1_row;
    logic [LW-1:0]      s1_lane;

    // First stage captures the resolved row and the lane select alongside it.
    always_ff @(posedge clk) begin
      if (reset) s1_valid <= 1'b0;
      else       s1_valid <= rd_go;
      if (rd_go) begin
        s1_row  <= rd_wide;
        s1_lane <= rd_lane;
      end
    end

    assign ld      = s1_valid;
    assign ld_data = pick(s1_row, s1_lane);
  end else begin : g_lat1
    assign ld      = rd_go;
    assign ld_data = pick(rd_wide, rd_lane);
  end

  // Output stage: data loads only with a valid and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_read_valid <= 1'b0;
      s_read_data  <= '0;
    end else begin
      s_read_valid <= ld;
      if (ld) s_read_data <= ld_data;
    end
  end

endmodule

// File: tb/tb_ram_asym_port.sv
// Self-checking bench: three RAM configurations against a row/lane array model.
module tb_ram_asym_port;

  localparam int unsigned WAW   = 6;
  localparam int unsigned NAW   = 8;
  localparam int unsigned DEPTH = 64;

  logic clk;
  logic reset;

  // Config A: wide write / narrow read, latency 1, write-first.
  logic           a_wreq;
  logic [WAW-1:0] a_waddr;
  logic [31:0]    a_wdata;
  logic [3:0]     a_wmask;
  logic           a_rreq;
  logic [NAW-1:0] a_raddr;
  logic [7:0]     a_rdata;
  logic           a_rvalid;

  // Configs B (write-first) and C (read-first): narrow write / wide read, latency 2.
  logic           n_wreq;
  logic [NAW-1:0] n_waddr;
  logic [7:0]     n_wdata;
  logic [3:0]     n_wmask;
  logic           n_rreq;
  logic [WAW-1:0] n_raddr;
  logic [31:0]    b_rdata;
  logic           b_rvalid;
  logic [31:0]    c_rdata;
  logic           c_rvalid;

  ram_asym_port #(.DATA_WIDTH(8), .RATIO(4), .WIDE_ADDR_W(WAW), .MODE(0),
                  .READ_LATENCY(1), .COLLISION_FWD(1)) u_a (
    .clk(clk), .reset(reset),
    .s_write_req(a_wreq), .s_write_addr(a_waddr), .s_write_data(a_wdata),
    .s_write_mask(a_wmask), .s_read_req(a_rreq), .s_read_addr(a_raddr),
    .s_read_data(a_rdata), .s_read_valid(a_rvalid));

  ram_asym_port #(.DATA_WIDTH(8), .RATIO(4), .WIDE_ADDR_W(WAW), .MODE(1),
                  .READ_LATENCY(2), .COLLISION_FWD(1)) u_b (
    .clk(clk), .reset(reset),
    .s_write_req(n_wreq), .s_write_addr(n_waddr), .s_write_data(n_wdata),
    .s_write_mask(n_wmask), .s_read_req(n_rreq), .s_read_addr(n_raddr),
    .s_read_data(b_rdata), .s_read_valid(b_rvalid));

  ram_asym_port #(.DATA_WIDTH(8), .RATIO(4), .WIDE_ADDR_W(WAW), .MODE(1),
                  .READ_LATENCY(2), .COLLISION_FWD(0)) u_c (
    .clk(clk), .reset(reset),
    .s_write_req(n_wreq), .s_write_addr(n_waddr), .s_write_data(n_wdata),
    .s_write_mask(n_wmask), .s_read_req(n_rreq), .s_read_addr(n_raddr),
    .s_read_data(c_rdata), .s_read_valid(c_rvalid));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_n [DEPTH];
  resp_t       qa[$];
  resp_t       qb[$];
  resp_t       qc[$];
  int          cyc;
  logic        exp_va, exp_vb, exp_vc;
  logic [31:0] exp_da, exp_db, exp_dc;
  logic [31:0] kw;
  int          n_cmp;
  int          n_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from the driven inputs, then compare.
  task automatic tick();
    logic [31:0] d_a, d_b, d_c;
    int row, lane;
    @(posedge clk);
    cyc++;
    if (reset) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (a_rreq) begin
        row  = int'(a_raddr[7:2]);
        lane = int'(a_raddr[1:0]);
        d_a  = {24'h0, mem_a[row][lane*8 +: 8]};
        if (a_wreq && int'(a_waddr) == row && a_wmask[lane])
          d_a = {24'h0, a_wdata[lane*8 +: 8]};
        qa.push_back('{due: cyc, data: d_a});
      end
      if (a_wreq)
        for (int i = 0; i < 4; i++)
          if (a_wmask[i]) mem_a[a_waddr][i*8 +: 8] = a_wdata[i*8 +: 8];
      if (n_rreq) begin
        row = int'(n_raddr);
        d_b = mem_n[row];
        d_c = mem_n[row];
        if (n_wreq && int'(n_waddr[7:2]) == row)
          d_b[int'(n_waddr[1:0])*8 +: 8] = n_wdata;
        qb.push_back('{due: cyc + 1, data: d_b});
        qc.push_back('{due: cyc + 1, data: d_c});
      end
      if (n_wreq) mem_n[n_waddr[7:2]][int'(n_waddr[1:0])*8 +: 8] = n_wdata;
    end
    exp_va = 1'b0;
    exp_vb = 1'b0;
    exp_vc = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin exp_va = 1'b1; exp_da = qa[0].data; void'(qa.pop_front()); end
    if (qb.size() > 0 && qb[0].due == cyc) begin exp_vb = 1'b1; exp_db = qb[0].data; void'(qb.pop_front()); end
    if (qc.size() > 0 && qc[0].due == cyc) begin exp_vc = 1'b1; exp_dc = qc[0].data; void'(qc.pop_front()); end
    if (reset) begin
      exp_da = '0; exp_db = '0; exp_dc = '0;
    end
    #1;
    chk("a_valid", 32'(a_rvalid), 32'(exp_va));
    chk("a_data", {24'h0, a_rdata}, exp_da);
    chk("b_valid", 32'(b_rvalid), 32'(exp_vb));
    chk("b_data", b_rdata, exp_db);
    chk("c_valid", 32'(c_rvalid), 32'(exp_vc));
    chk("c_data", c_rdata, exp_dc);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    a_wreq = 0; a_waddr = '0; a_wdata = '0; a_wmask = '0; a_rreq = 0; a_raddr = '0;
    n_wreq = 0; n_waddr = '0; n_wdata = '0; n_wmask = '0; n_rreq = 0; n_raddr = '0;
    n_cmp = 0; n_mis = 0; cyc = 0;
    exp_va = 0; exp_vb = 0; exp_vc = 0; exp_da = '0; exp_db = '0; exp_dc = '0;

    repeat (3) tick();
    reset = 1'b0;

    // Fill every location so later reads are fully defined.
    for (int i = 0; i < 256; i++) begin
      a_wreq = (i < 64); a_waddr = WAW'(i); a_wdata = $urandom(); a_wmask = 4'hF;
      n_wreq = 1'b1; n_waddr = NAW'(i); n_wdata = 8'($urandom()); n_wmask = 4'($urandom());
      tick();
    end
    a_wreq = 0; n_wreq = 0;

    // Full-row write then four back-to-back narrow reads.
    a_wreq = 1; a_waddr = 6'd3; a_wdata = 32'hDDCC_BBAA; a_wmask = 4'hF;
    tick();
    a_wreq = 0;
    kw = 32'hDDCC_BBAA;
    for (int i = 0; i < 4; i++) begin
      a_rreq = 1; a_raddr = NAW'(12 + i);
      tick();
      chk("full_valid", 32'(a_rvalid), 32'd1);
      chk("full_data", {24'h0, a_rdata}, {24'h0, kw[i*8 +: 8]});
    end
    a_rreq = 0;
    tick();
    chk("full_idle_valid", 32'(a_rvalid), 32'd0);

    // Masked write touches lanes 0 and 2 only.
    a_wreq = 1; a_waddr = 6'd3; a_wdata = 32'h4433_2211; a_wmask = 4'b0101;
    tick();
    a_wreq = 0;
    kw = 32'hDD33_BB11;
    for (int i = 0; i < 4; i++) begin
      a_rreq = 1; a_raddr = NAW'(12 + i);
      tick();
      chk("mask_data", {24'h0, a_rdata}, {24'h0, kw[i*8 +: 8]});
    end

    // Read data holds while no further reads are issued.
    a_rreq = 1; a_raddr = 8'd13;
    tick();
    chk("hold_first", {24'h0, a_rdata}, 32'hBB);
    a_rreq = 0;
    repeat (5) begin
      tick();
      chk("hold_data", {24'h0, a_rdata}, 32'hBB);
      chk("hold_valid", 32'(a_rvalid), 32'd0);
    end

    // Narrow writes assembled into one wide row, latency 2.
    for (int i = 0; i < 4; i++) begin
      n_wreq = 1; n_waddr = NAW'(20 + i); n_wdata = 8'(i + 1);
      tick();
    end
    n_wreq = 0;
    n_rreq = 1; n_raddr = 6'd5;
    tick();
    chk("lat2_early", 32'(b_rvalid), 32'd0);
    n_rreq = 0;
    tick();
    chk("lat2_valid", 32'(b_rvalid), 32'd1);
    chk("lat2_b_data", b_rdata, 32'h0403_0201);
    chk("lat2_c_data", c_rdata, 32'h0403_0201);

    // Same-edge write and read of row 5.
    n_wreq = 1; n_waddr = 8'd21; n_wdata = 8'hEE; n_rreq = 1; n_raddr = 6'd5;
    tick();
    n_wreq = 0; n_rreq = 0;
    tick();
    chk("coll_fwd", b_rdata, 32'h0403_EE01);
    chk("coll_old", c_rdata, 32'h0403_0201);
    n_rreq = 1;
    tick();
    n_rreq = 0;
    tick();
    chk("coll_after", c_rdata, 32'h0403_EE01);

    // Reset while a read is in flight discards it.
    n_rreq = 1; n_raddr = 6'd5;
    tick();
    n_rreq = 0; reset = 1;
    tick();
    chk("rst_valid", 32'(b_rvalid), 32'd0);
    chk("rst_data", b_rdata, 32'd0);
    tick();
    reset = 0; n_rreq = 1;
    tick();
    chk("rst_no_stale", 32'(b_rvalid), 32'd0);
    n_rreq = 0;
    tick();
    chk("rst_reread_valid", 32'(b_rvalid), 32'd1);
    chk("rst_reread_data", b_rdata, 32'h0403_EE01);

    // Random traffic on a few rows to provoke collisions, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      a_wreq  = 1'($urandom_range(0, 1));
      a_waddr = WAW'($urandom_range(0, 3));
      a_wdata = $urandom();
      a_wmask = 4'($urandom());
      a_rreq  = 1'($urandom_range(0, 1));
      a_raddr = NAW'($urandom_range(0, 15));
      n_wreq  = 1'($urandom_range(0, 1));
      n_waddr = NAW'($urandom_range(0, 15));
      n_wdata = 8'($urandom());
      n_wmask = 4'($urandom());
      n_rreq  = 1'($urandom_range(0, 1));
      n_raddr = WAW'($urandom_range(0, 3));
      tick();
    end
    reset = 0; a_wreq = 0; a_rreq = 0; n_wreq = 0; n_rreq = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
